// File: rtl/ps2_command_out.sv
// ps2_command_out: host-to-device PS/2 command transmitter with inhibit, framing, ACK check and timeouts
module ps2_command_out #(
  parameter int CLK_HOLD_CYCLES = 5000,
  parameter int START_TIMEOUT   = 750000,
  parameter int XFER_TIMEOUT    = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] the_command,
  input  logic       send_command,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
  output logic       busy,
  output logic       command_was_sent,
  output logic       error_communication_timed_out
);
  localparam logic [19:0] HOLD_LAST  = 20'(CLK_HOLD_CYCLES - 1);
  localparam logic [19:0] START_LAST = 20'(START_TIMEOUT - 1);
  localparam logic [19:0] XFER_LAST  = 20'(XFER_TIMEOUT - 1);
  typedef enum logic [3:0] {IDLE, INHIBIT, START, DATA, PARITY, STOP, WAIT_ACK, DONE, ERROR} state_t;
  state_t      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [2:0]  bit_q, bit_d;
  logic [19:0] cnt_q, cnt_d, xfer_q, xfer_d;
  logic [1:0]  clk_sync_q, dat_sync_q;
  logic        clk_prev_q;
  logic        fall, xfer_exp, clk_low, dat_low;
  assign fall     = clk_prev_q & ~clk_sync_q[1];
  assign xfer_exp = xfer_q >= XFER_LAST;
  // Registers: line synchronizers, FSM state, latched byte, bit index and saturating counters
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= IDLE;
      cmd_q      <= 8'h00;
      bit_q      <= 3'd0;
      cnt_q      <= 20'd0;
      xfer_q     <= 20'd0;
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      bit_q      <= bit_d;
      cnt_q      <= cnt_d;
      xfer_q     <= xfer_d;
      clk_sync_q <= {clk_sync_q[0], PS2_CLK};
      dat_sync_q <= {dat_sync_q[0], PS2_DAT};
      clk_prev_q <= clk_sync_q[1];
    end
  end
  // Next state: device clock edges step the frame; timeouts and a missing ACK divert to ERROR
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q + {19'd0, cnt_q != 20'hFFFFF};
    xfer_d  = xfer_q + {19'd0, xfer_q != 20'hFFFFF};
    case (state_q)
      IDLE: begin
        cnt_d  = 20'd0;
        xfer_d = 20'd0;
        bit_d  = 3'd0;
        if (send_command) begin
          cmd_d   = the_command;
          state_d = INHIBIT;
        end
      end
      INHIBIT: if (cnt_q >= HOLD_LAST) begin
        state_d = START;
        cnt_d   = 20'd0;
      end
      START: begin
        if (fall) begin
          state_d = DATA;
          bit_d   = 3'd0;
          xfer_d  = 20'd0;
        end else if (cnt_q >= START_LAST) state_d = ERROR;
      end
      DATA: begin
        if (xfer_exp) state_d = ERROR;
        else if (fall) begin
          bit_d   = bit_q + 3'd1;
          state_d = bit_q == 3'd7 ? PARITY : DATA;
        end
      end
      PARITY:   state_d = xfer_exp ? ERROR : fall ? STOP : PARITY;
      STOP:     state_d = xfer_exp ? ERROR : fall ? WAIT_ACK : STOP;
      WAIT_ACK: state_d = xfer_exp ? ERROR : fall ? (dat_sync_q[1] ? ERROR : DONE) : WAIT_ACK;
      default:  state_d = IDLE;
    endcase
  end
  assign clk_low = state_q == INHIBIT;
  assign dat_low = (state_q == INHIBIT && cnt_q >= HOLD_LAST) || state_q == START ||
                   (state_q == DATA && !cmd_q[bit_q]) || (state_q == PARITY && ^cmd_q);
  assign PS2_CLK = clk_low ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_low ? 1'b0 : 1'bz;
  assign busy = state_q != IDLE;
  assign command_was_sent = state_q == DONE;
  assign error_communication_timed_out = state_q == ERROR;
endmodule

// File: tb/tb_ps2_command_out.sv
// tb_ps2_command_out: scoreboard bench with a PS/2 device model driving the open-drain lines
module tb_ps2_command_out;
  localparam int HOLD = 50;
  localparam int ST   = 300;
  localparam int XF   = 600;
  localparam int HALF = 20;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] the_command;
  logic       send_command;
  logic       busy, command_was_sent, error_communication_timed_out;
  logic       dev_clk, dev_dat;
  wire        ps2_clk, ps2_dat;
  int         total = 0;
  int         bad = 0;
  bit         exp_q[$];
  assign ps2_clk = dev_clk ? 1'b0 : 1'bz;
  assign ps2_dat = dev_dat ? 1'b0 : 1'bz;
  pullup (ps2_clk);
  pullup (ps2_dat);
  ps2_command_out #(.CLK_HOLD_CYCLES(HOLD), .START_TIMEOUT(ST), .XFER_TIMEOUT(XF)) dut (
    .CLOCK_50(clk), .reset(reset), .the_command(the_command), .send_command(send_command),
    .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat), .busy(busy), .command_was_sent(command_was_sent),
    .error_communication_timed_out(error_communication_timed_out));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    the_command = b;
    send_command = 1'b1;
    @(negedge clk);
    send_command = 1'b0;
  endtask
  task automatic wait_release(output int hold);
    int n = 0;
    while (ps2_clk !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    hold = 0;
    while (ps2_clk === 1'b0 && hold < HOLD * 4) begin
      @(negedge clk);
      hold++;
    end
  endtask
  task automatic device(input int nclk, input bit ack, output logic [9:0] frame);
    frame = '0;
    repeat (4) @(negedge clk);
    chk("start_bit", int'(ps2_dat), 0);
    for (int i = 1; i <= nclk; i++) begin
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      if (i <= 10) frame[i-1] = ps2_dat;
      if (i == 11 && ack) dev_dat = 1'b1;
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    dev_dat = 1'b0;
  endtask
  // Monitor: every completion/error pulse is matched against the next expected outcome
  initial forever begin
    @(negedge clk);
    if (command_was_sent || error_communication_timed_out) begin
      chk("pulse_exclusive", int'(command_was_sent & error_communication_timed_out), 0);
      if (exp_q.size() == 0) chk("unexpected_pulse", 1, 0);
      else chk("outcome_sent", int'(command_was_sent), int'(exp_q.pop_front()));
      @(negedge clk);
      chk("busy_after_pulse", int'(busy), 0);
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int hold, k;
    logic [9:0] frame;
    reset = 1'b1; send_command = 1'b0; the_command = 8'h00; dev_clk = 1'b0; dev_dat = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_sent", int'(command_was_sent), 0);
    chk("reset_err", int'(error_communication_timed_out), 0);
    chk("reset_clk", int'(ps2_clk), 1);
    chk("reset_dat", int'(ps2_dat), 1);
    reset = 1'b0;
    exp_q.push_back(1'b1);
    send(8'hED);
    wait_release(hold);
    chk("ed_hold", hold, HOLD);
    device(12, 1'b1, frame);
    chk("ed_frame", int'(frame), int'(10'b11_1110_1101));
    repeat (10) @(negedge clk);
    exp_q.push_back(1'b1);
    send(8'hF4);
    wait_release(hold);
    chk("f4_hold", hold, HOLD);
    device(12, 1'b1, frame);
    chk("f4_frame", int'(frame), int'(10'b10_1111_0100));
    repeat (10) @(negedge clk);
    exp_q.push_back(1'b0);
    send(8'h5A);
    wait_release(hold);
    k = 0;
    while (!error_communication_timed_out && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("start_timeout_cycles", k, ST);
    chk("start_timeout_clk", int'(ps2_clk), 1);
    chk("start_timeout_dat", int'(ps2_dat), 1);
    repeat (10) @(negedge clk);
    exp_q.push_back(1'b0);
    send(8'h3C);
    wait_release(hold);
    device(12, 1'b0, frame);
    chk("nack_frame", int'(frame), int'(10'b11_0011_1100));
    repeat (10) @(negedge clk);
    exp_q.push_back(1'b0);
    send(8'hA5);
    wait_release(hold);
    device(4, 1'b0, frame);
    repeat (XF + 50) @(negedge clk);
    chk("xfer_timeout_dat", int'(ps2_dat), 1);
    send(8'h00);
    wait_release(hold);
    device(5, 1'b0, frame);
    chk("abort_busy_before", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_clk", int'(ps2_clk), 1);
    chk("abort_dat", int'(ps2_dat), 1);
    repeat (XF + 50) @(negedge clk);
    exp_q.push_back(1'b1);
    send(8'h00);
    wait_release(hold);
    device(12, 1'b1, frame);
    chk("zero_frame", int'(frame), int'(10'b11_0000_0000));
    repeat (10) @(negedge clk);
    exp_q.push_back(1'b1);
    send(8'hED);
    repeat (10) @(negedge clk);
    the_command = 8'hFF;
    send_command = 1'b1;
    @(negedge clk);
    send_command = 1'b0;
    wait_release(hold);
    device(12, 1'b1, frame);
    chk("double_frame", int'(frame), int'(10'b11_1110_1101));
    repeat (50) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
